cam_op_arbiter: RTL and testbench
=================================

// Module: cam_op_arbiter
// PURPOSE
//   Shares the single CAM/TCAM table-update port between three byte-serial requesters: config (write), change and delete.
//   Grants one requester at a time round-robin, forwards its key stream to the table with an opcode, then holds the port
//   until the table acknowledges or a timeout fires. Sits between the register-driven op generators and the CAM core.
// PARAMETERS
//   LOOK_UP_DATA_WIDTH   280   key width in bits; BEATS = LOOK_UP_DATA_WIDTH/PORT_MNG_DATA_WIDTH beats per op (35)
//   PORT_MNG_DATA_WIDTH  8     beat width in bits
//   CNT_W                6     beat index width = clog2(LOOK_UP_DATA_WIDTH/8)
//   TIMEOUT_CYC          1024  max cycles in WAIT_ACK before abort
// PORTS
//   i_clk            in   1      clock
//   i_rst            in   1      synchronous active-high reset
//   i_req            in   3      level request per source, [0]=config [1]=change [2]=delete; held until o_done
//   o_gnt            out  3      one-hot grant; high from grant cycle through last beat accepted
//   i_data           in   3*PORT_MNG_DATA_WIDTH  per-source beat data, source k at [k*W +: W]
//   i_data_cnt       in   3*CNT_W per-source beat index
//   i_data_vld       in   3      per-source beat valid
//   o_cam_data       out  PORT_MNG_DATA_WIDTH  forwarded beat
//   o_cam_data_cnt   out  CNT_W  forwarded beat index
//   o_cam_data_vld   out  1      forwarded beat valid
//   o_cam_op         out  2      opcode of current op: 0=config 1=change 2=delete, valid while o_cam_data_vld
//   i_cam_done       in   1      single-cycle table completion pulse
//   o_done           out  3      one-cycle completion pulse to owning source
//   o_err            out  1      qualifies o_done: 1 = timeout or beat-index error
//   i_err_cnt_clr    in   1      clears o_err_cnt
//   o_err_cnt        out  16     saturating count of errored ops
//   o_busy           out  1      high in any state but IDLE
// BEHAVIOUR
//   Reset: all outputs 0, FSM=IDLE, round-robin pointer=0 (config highest), beat counter=0, timer=0, o_err_cnt=0.
//   FSM IDLE -> STREAM -> WAIT_ACK -> DONE -> IDLE.
//   IDLE: if any i_req, pick first requester at or after pointer (mod 3); register o_gnt next cycle, enter STREAM.
//     Pointer updates to winner+1 (mod 3) on grant. No i_req: stay IDLE.
//   STREAM: only the granted source's i_data_vld is observed; other sources' vld ignored (they must not stream).
//     Each accepted beat is forwarded registered: o_cam_* = beat one cycle later (latency 1), o_cam_op = grant index.
//     Internal expected index starts 0, +1 per beat; if i_data_cnt != expected, set sticky op-error (beat still forwarded).
//     Beat with expected == BEATS-1 is last: o_gnt drops next cycle, timer cleared, enter WAIT_ACK.
//     Deassertion of i_req mid-stream ignored; no timeout in STREAM (source owns pacing).
//   WAIT_ACK: timer +1 per cycle. i_cam_done -> DONE, err=op-error. Timer reaching TIMEOUT_CYC-1 -> DONE, err=1.
//     i_cam_done and timeout in same cycle: done wins (err = op-error only).
//     i_cam_done outside WAIT_ACK: ignored.
//   DONE (1 cycle): o_done[grant]=1, o_err=err; if err, o_err_cnt +1 saturating at 16'hFFFF; clear op-error; -> IDLE.
//     Earliest re-grant: cycle after DONE; a source must drop i_req within the cycle after o_done or is re-arbitrated.
//   i_err_cnt_clr: o_err_cnt=0 next cycle; simultaneous with increment, clear wins.
//   Reset mid-operation: immediate return to IDLE, no o_done issued, partial stream abandoned.
// TESTING
//   Single config op, 35 beats cnt 0..34, i_cam_done 5 cyc after last -> o_cam_op=0 on all 35 beats, o_done=3'b001, o_err=0.
//   i_req=3'b111 held, each op acked -> grant order config,change,delete,config; o_cam_op 0,1,2,0.
//   Delete op, no i_cam_done -> o_done=3'b100, o_err=1 exactly TIMEOUT_CYC cycles after WAIT_ACK entry; o_err_cnt=1.
//   Change op beat 10 sent with cnt=11 -> all 35 beats forwarded, ack -> o_err=1, o_err_cnt increments.
//   i_cam_done on the final timeout cycle -> o_err=0; i_cam_done while IDLE -> no o_done, state unchanged.
//   Reset asserted at beat 20 -> next cycle o_gnt=0, o_cam_data_vld=0, o_busy=0, o_err_cnt=0, pointer=0.

Source files
------------

// File: rtl/cam_op_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cam_op_arbiter
// Purpose  : Shares the single CAM/TCAM table-update port between three
//            byte-serial requesters (config, change, delete). Grants one
//            source at a time round-robin, forwards its key beats to the table
//            with an opcode, then holds the port until the table acknowledges
//            or a timeout fires.
// Ports    : i_clk / i_rst      clock, synchronous active-high reset
//            i_req / o_gnt      per-source level request, one-hot grant
//            i_data*            per-source beat data / index / valid
//            o_cam_*            forwarded beat (1-cycle latency) + opcode
//            i_cam_done         table completion pulse
//            o_done / o_err     completion pulse to owner, error qualifier
//            i_err_cnt_clr      clears o_err_cnt
//            o_err_cnt          saturating errored-op counter
//            o_busy             high whenever not IDLE
// Revision : 1.0 - initial release
// ============================================================================
module cam_op_arbiter #(
    parameter int LOOK_UP_DATA_WIDTH  = 280,
    parameter int PORT_MNG_DATA_WIDTH = 8,
    parameter int CNT_W               = 6,
    parameter int TIMEOUT_CYC         = 1024
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic [2:0]                       i_req,
    output logic [2:0]                       o_gnt,
    input  logic [3*PORT_MNG_DATA_WIDTH-1:0] i_data,
    input  logic [3*CNT_W-1:0]               i_data_cnt,
    input  logic [2:0]                       i_data_vld,
    output logic [PORT_MNG_DATA_WIDTH-1:0]   o_cam_data,
    output logic [CNT_W-1:0]                 o_cam_data_cnt,
    output logic                             o_cam_data_vld,
    output logic [1:0]                       o_cam_op,
    input  logic                             i_cam_done,
    output logic [2:0]                       o_done,
    output logic                             o_err,
    input  logic                             i_err_cnt_clr,
    output logic [15:0]                      o_err_cnt,
    output logic                             o_busy
);

    localparam int                 c_BEATS     = LOOK_UP_DATA_WIDTH / PORT_MNG_DATA_WIDTH;
    localparam int                 c_TMR_W     = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CNT_W-1:0]   c_LAST_BEAT = CNT_W'(c_BEATS - 1);
    localparam logic [c_TMR_W-1:0] c_TMO_LAST  = c_TMR_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_STREAM   = 2'd1,
        S_WAIT_ACK = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t                         r_state;
    state_t                         w_state_nxt;

    logic [1:0]                     r_ptr;
    logic [1:0]                     r_gnt_idx;
    logic [2:0]                     r_gnt;
    logic [CNT_W-1:0]               r_beat_cnt;
    logic                           r_op_err;
    logic [c_TMR_W-1:0]             r_timer;
    logic [PORT_MNG_DATA_WIDTH-1:0] r_cam_data;
    logic [CNT_W-1:0]               r_cam_cnt;
    logic                           r_cam_vld;
    logic [1:0]                     r_cam_op;
    logic [2:0]                     r_done;
    logic                           r_err;
    logic [15:0]                    r_err_cnt;

    logic [1:0]                     w_win_idx;
    logic [1:0]                     w_ptr_nxt;
    logic [PORT_MNG_DATA_WIDTH-1:0] w_sel_data;
    logic [CNT_W-1:0]               w_sel_cnt;
    logic                           w_sel_vld;
    logic                           w_beat;
    logic                           w_last;
    logic                           w_tmo_hit;
    logic                           w_to_done;

    // Round-robin pick: first requester at or after the pointer, mod 3.
    always_comb begin
        w_win_idx = 2'd0;
        case (r_ptr)
            2'd1: begin
                if      (i_req[1]) w_win_idx = 2'd1;
                else if (i_req[2]) w_win_idx = 2'd2;
                else               w_win_idx = 2'd0;
            end
            2'd2: begin
                if      (i_req[2]) w_win_idx = 2'd2;
                else if (i_req[0]) w_win_idx = 2'd0;
                else               w_win_idx = 2'd1;
            end
            default: begin
                if      (i_req[0]) w_win_idx = 2'd0;
                else if (i_req[1]) w_win_idx = 2'd1;
                else               w_win_idx = 2'd2;
            end
        endcase
        w_ptr_nxt = (w_win_idx == 2'd2) ? 2'd0 : (w_win_idx + 2'd1);
    end

    // Only the granted source's beat lane is observed.
    always_comb begin
        w_sel_data = '0;
        w_sel_cnt  = '0;
        w_sel_vld  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (r_gnt_idx == 2'(k)) begin
                w_sel_data = i_data[k*PORT_MNG_DATA_WIDTH +: PORT_MNG_DATA_WIDTH];
                w_sel_cnt  = i_data_cnt[k*CNT_W +: CNT_W];
                w_sel_vld  = i_data_vld[k];
            end
        end
    end

    assign w_beat    = (r_state == S_STREAM) && w_sel_vld;
    assign w_last    = w_beat && (r_beat_cnt == c_LAST_BEAT);
    assign w_tmo_hit = (r_timer == c_TMO_LAST);
    assign w_to_done = (r_state == S_WAIT_ACK) && (i_cam_done || w_tmo_hit);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (|i_req)    w_state_nxt = S_STREAM;
            S_STREAM:   if (w_last)    w_state_nxt = S_WAIT_ACK;
            S_WAIT_ACK: if (w_to_done) w_state_nxt = S_DONE;
            S_DONE:                    w_state_nxt = S_IDLE;
            default:                   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr      <= '0;
            r_gnt_idx  <= '0;
            r_gnt      <= '0;
            r_beat_cnt <= '0;
            r_op_err   <= 1'b0;
            r_timer    <= '0;
            r_cam_data <= '0;
            r_cam_cnt  <= '0;
            r_cam_vld  <= 1'b0;
            r_cam_op   <= '0;
            r_done     <= '0;
            r_err      <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            // Forward every accepted beat one cycle later, tagged with the grant.
            r_cam_vld <= w_beat;
            if (w_beat) begin
                r_cam_data <= w_sel_data;
                r_cam_cnt  <= w_sel_cnt;
                r_cam_op   <= r_gnt_idx;
            end

            // Completion pulse is registered on entry to DONE so it lines up
            // with the DONE cycle. Ack takes priority over the timeout.
            r_done <= '0;
            r_err  <= 1'b0;
            if (w_to_done) begin
                r_done <= 3'b001 << r_gnt_idx;
                r_err  <= i_cam_done ? r_op_err : 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (|i_req) begin
                        r_gnt      <= 3'b001 << w_win_idx;
                        r_gnt_idx  <= w_win_idx;
                        r_ptr      <= w_ptr_nxt;
                        r_beat_cnt <= '0;
                    end
                end
                S_STREAM: begin
                    if (w_beat) begin
                        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                        // Index mismatch is sticky; the beat is still forwarded.
                        if (w_sel_cnt != r_beat_cnt) r_op_err <= 1'b1;
                    end
                    if (w_last) begin
                        r_gnt   <= '0;
                        r_timer <= '0;
                    end
                end
                S_WAIT_ACK: begin
                    r_timer <= r_timer + c_TMR_W'(1);
                end
                S_DONE: begin
                    r_op_err <= 1'b0;
                end
                default: ;
            endcase

            // Clear takes priority over a same-cycle increment.
            if (i_err_cnt_clr)
                r_err_cnt <= '0;
            else if ((r_state == S_DONE) && r_err && (r_err_cnt != 16'hFFFF))
                r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign o_gnt          = r_gnt;
    assign o_cam_data     = r_cam_data;
    assign o_cam_data_cnt = r_cam_cnt;
    assign o_cam_data_vld = r_cam_vld;
    assign o_cam_op       = r_cam_op;
    assign o_done         = r_done;
    assign o_err          = r_err;
    assign o_err_cnt      = r_err_cnt;
    assign o_busy         = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_cam_op_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cam_op_arbiter
// Purpose  : Directed self-checking bench for cam_op_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cam_op_arbiter;

    localparam int W     = 8;
    localparam int CW    = 6;
    localparam int BEATS = 35;
    localparam int TMO   = 1024;

    logic            clk = 1'b0;
    logic            rst;
    logic [2:0]      req;
    logic [2:0]      gnt;
    logic [3*W-1:0]  data;
    logic [3*CW-1:0] dcnt;
    logic [2:0]      dvld;
    logic [W-1:0]    cam_data;
    logic [CW-1:0]   cam_cnt;
    logic            cam_vld;
    logic [1:0]      cam_op;
    logic            cam_done;
    logic [2:0]      done;
    logic            err;
    logic            clr;
    logic [15:0]     err_cnt;
    logic            busy;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    cam_op_arbiter #(
        .LOOK_UP_DATA_WIDTH (280),
        .PORT_MNG_DATA_WIDTH(W),
        .CNT_W              (CW),
        .TIMEOUT_CYC        (TMO)
    ) u_dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_req         (req),
        .o_gnt         (gnt),
        .i_data        (data),
        .i_data_cnt    (dcnt),
        .i_data_vld    (dvld),
        .o_cam_data    (cam_data),
        .o_cam_data_cnt(cam_cnt),
        .o_cam_data_vld(cam_vld),
        .o_cam_op      (cam_op),
        .i_cam_done    (cam_done),
        .o_done        (done),
        .o_err         (err),
        .i_err_cnt_clr (clr),
        .o_err_cnt     (err_cnt),
        .o_busy        (busy)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] pat(input int src, input int j);
        return 8'((j * 7 + src * 50 + 3) & 255);
    endfunction

    // Steps until a grant appears (bounded), then checks it.
    task automatic grant_wait(input string tag, input logic [2:0] exp);
        for (int n = 0; n < 8 && gnt == 3'b000; n++) step();
        chk(tag, 32'(gnt), 32'(exp));
    endtask

    // Streams nb beats from src back to back; beat 'bad' carries index+1.
    task automatic send_op(input int src, input int bad, input int nb);
        logic [16:0] e;
        for (int j = 0; j < nb; j++) begin
            dvld                 = 3'b000;
            dvld[src]            = 1'b1;
            data[src*W +: W]     = pat(src, j);
            dcnt[src*CW +: CW]   = CW'((j == bad) ? j + 1 : j);
            step();
            e = {1'b1, 2'(src), CW'((j == bad) ? j + 1 : j), pat(src, j)};
            chk($sformatf("beat%0d_s%0d", j, src),
                32'({cam_vld, cam_op, cam_cnt, cam_data}), 32'(e));
        end
        dvld = 3'b000;
    endtask

    task automatic do_ack(input int d);
        repeat (d) step();
        cam_done = 1'b1;
        step();
        cam_done = 1'b0;
    endtask

    initial begin
        int early;
        rst      = 1'b1;
        req      = '0;
        data     = '0;
        dcnt     = '0;
        dvld     = '0;
        cam_done = 1'b0;
        clr      = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_gnt",     32'(gnt),      32'h0);
        chk("rst_vld",     32'(cam_vld),  32'h0);
        chk("rst_busy",    32'(busy),     32'h0);
        chk("rst_done",    32'(done),     32'h0);
        chk("rst_err",     32'(err),      32'h0);
        chk("rst_err_cnt", 32'(err_cnt),  32'h0);

        // Single config op, ack 5 cycles after last beat
        req = 3'b001;
        grant_wait("t1_gnt", 3'b001);
        chk("t1_busy", 32'(busy), 32'h1);
        send_op(0, -1, BEATS);
        chk("t1_gnt_drop", 32'(gnt),  32'h0);
        chk("t1_busy_wait", 32'(busy), 32'h1);
        step();
        chk("t1_vld_off", 32'(cam_vld), 32'h0);
        do_ack(3);
        chk("t1_done", 32'(done), 32'h1);
        chk("t1_err",  32'(err),  32'h0);
        req = 3'b000;
        step();
        chk("t1_done_pulse", 32'(done), 32'h0);
        chk("t1_idle", 32'(busy), 32'h0);
        chk("t1_err_cnt", 32'(err_cnt), 32'h0);

        // Round-robin with all three requesting from a fresh pointer
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = 3'b111;
        for (int i = 0; i < 4; i++) begin
            grant_wait($sformatf("t2_gnt%0d", i), 3'b001 << (i % 3));
            send_op(i % 3, -1, BEATS);
            do_ack(1);
            chk($sformatf("t2_done%0d", i), 32'(done), 32'(3'b001 << (i % 3)));
            if (i == 3) req = 3'b000;
        end
        step();

        // Delete op timing out
        req = 3'b100;
        grant_wait("t3_gnt", 3'b100);
        send_op(2, -1, BEATS);
        early = 0;
        for (int k = 1; k < TMO; k++) begin
            step();
            if (done != 3'b000) early++;
        end
        chk("t3_no_early", 32'(early), 32'h0);
        step();
        chk("t3_done", 32'(done), 32'h4);
        chk("t3_err",  32'(err),  32'h1);
        req = 3'b000;
        step();
        chk("t3_err_cnt", 32'(err_cnt), 32'h1);

        // Change op with a bad beat index
        req = 3'b010;
        grant_wait("t4_gnt", 3'b010);
        send_op(1, 10, BEATS);
        do_ack(2);
        chk("t4_done", 32'(done), 32'h2);
        chk("t4_err",  32'(err),  32'h1);
        req = 3'b000;
        step();
        chk("t4_err_cnt", 32'(err_cnt), 32'h2);

        // Ack on the final timeout cycle wins
        req = 3'b001;
        grant_wait("t5_gnt", 3'b001);
        send_op(0, -1, BEATS);
        repeat (TMO - 1) step();
        cam_done = 1'b1;
        step();
        cam_done = 1'b0;
        chk("t5_done", 32'(done), 32'h1);
        chk("t5_err",  32'(err),  32'h0);
        req = 3'b000;
        step();
        chk("t5_err_cnt", 32'(err_cnt), 32'h2);

        // Ack while idle is ignored
        cam_done = 1'b1;
        step();
        cam_done = 1'b0;
        chk("t5b_done", 32'(done), 32'h0);
        chk("t5b_busy", 32'(busy), 32'h0);
        step();
        chk("t5b_done2", 32'(done), 32'h0);

        // Reset at beat 20; pointer must return to config-first
        req = 3'b010;
        grant_wait("t6_gnt", 3'b010);
        send_op(1, -1, 20);
        rst  = 1'b1;
        step();
        chk("t6_gnt",     32'(gnt),     32'h0);
        chk("t6_vld",     32'(cam_vld), 32'h0);
        chk("t6_busy",    32'(busy),    32'h0);
        chk("t6_err_cnt", 32'(err_cnt), 32'h0);
        chk("t6_done",    32'(done),    32'h0);
        rst = 1'b0;
        req = 3'b110;
        grant_wait("t6_ptr", 3'b010);

        // Errored op whose increment coincides with a counter clear
        send_op(1, 3, BEATS);
        do_ack(1);
        chk("t7_done", 32'(done), 32'h2);
        chk("t7_err",  32'(err),  32'h1);
        req = 3'b000;
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("t7_clr_wins", 32'(err_cnt), 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
